// File: rtl/codec_init_seq.sv
// codec_init_seq: drives the codec_prgm I2C writer. After reset it walks the
// 11-entry WM8731 init table, one 3-byte write per entry, then serves single
// register writes from one user requester. Runs entirely on the I2C bit-rate clock.
module codec_init_seq #(
    parameter logic [7:0] SLAVE_ADDR = 8'h34,
    parameter int         GAP_CYCLES = 4,
    parameter int         TIMEOUT    = 63
) (
    input  logic        i_clk_br,
    input  logic        i_ar,
    input  logic        i_start,
    input  logic        i_usr_req,
    input  logic [6:0]  i_usr_addr,
    input  logic [8:0]  i_usr_data,
    output logic        o_usr_ack,
    input  logic        i_prgm_done,
    output logic [23:0] o_data_codec,
    output logic        o_activate,
    output logic        o_busy,
    output logic        o_init_done,
    output logic        o_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_XFER,
        S_RELEASE,
        S_GAP
    } state_t;

    localparam logic [3:0] LAST_IDX   = 4'd10;
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP_CYCLES - 1);

    state_t      r_state;
    logic [3:0]  r_idx;
    logic        r_src_user;
    logic        r_start_pend;
    logic [7:0]  r_timer;
    logic [7:0]  r_gap;
    logic        r_activate;
    logic [23:0] r_data_codec;
    logic        r_busy;
    logic        r_init_done;
    logic        r_usr_ack;
    logic        r_err;

    logic [15:0] w_next_entry;

    // Init table: {register address[6:0], register value[8:0]}
    function automatic logic [15:0] f_table(input logic [3:0] idx);
        logic [15:0] entry;
        case (idx)
            4'd0:    entry = {7'd15, 9'h000};
            4'd1:    entry = {7'd0,  9'h017};
            4'd2:    entry = {7'd1,  9'h017};
            4'd3:    entry = {7'd2,  9'h079};
            4'd4:    entry = {7'd3,  9'h079};
            4'd5:    entry = {7'd4,  9'h012};
            4'd6:    entry = {7'd5,  9'h000};
            4'd7:    entry = {7'd6,  9'h000};
            4'd8:    entry = {7'd7,  9'h002};
            4'd9:    entry = {7'd8,  9'h000};
            4'd10:   entry = {7'd9,  9'h001};
            default: entry = 16'h0000;
        endcase
        return entry;
    endfunction

    // Entry following the current one, loaded when GAP advances the table
    assign w_next_entry = f_table(r_idx + 4'd1);

    // Sequencer: the transfer word is latched on entry to LOAD so it is stable
    // a full cycle before activate rises and for the whole transfer.
    always_ff @(posedge i_clk_br or negedge i_ar) begin
        if (!i_ar) begin
            r_state      <= S_IDLE;
            r_idx        <= 4'd0;
            r_src_user   <= 1'b0;
            r_start_pend <= 1'b0;
            r_timer      <= 8'd0;
            r_gap        <= 8'd0;
            r_activate   <= 1'b0;
            r_data_codec <= 24'd0;
            r_busy       <= 1'b0;
            r_init_done  <= 1'b0;
            r_usr_ack    <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_usr_ack <= 1'b0;
            if (i_start) begin
                r_start_pend <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    // IDLE with init_done low only happens right after reset,
                    // which must kick off the table just like a start request.
                    if (r_start_pend || !r_init_done) begin
                        r_start_pend <= i_start;
                        r_idx        <= 4'd0;
                        r_src_user   <= 1'b0;
                        r_err        <= 1'b0;
                        r_init_done  <= 1'b0;
                        r_busy       <= 1'b1;
                        r_data_codec <= {SLAVE_ADDR, f_table(4'd0)};
                        r_state      <= S_LOAD;
                    end else if (i_usr_req) begin
                        r_src_user   <= 1'b1;
                        r_usr_ack    <= 1'b1;
                        r_busy       <= 1'b1;
                        r_data_codec <= {SLAVE_ADDR, i_usr_addr, i_usr_data};
                        r_state      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_timer    <= 8'd0;
                    r_activate <= 1'b1;
                    r_state    <= S_XFER;
                end
                S_XFER: begin
                    if (i_prgm_done) begin
                        r_activate <= 1'b0;
                        r_state    <= S_RELEASE;
                    end else if (r_timer == TIMER_LAST) begin
                        // Give up on this entry but keep walking the table
                        r_err      <= 1'b1;
                        r_activate <= 1'b0;
                        r_state    <= S_RELEASE;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                S_RELEASE: begin
                    if (!i_prgm_done) begin
                        r_gap   <= 8'd0;
                        r_state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_gap == GAP_LAST) begin
                        if (r_start_pend || r_src_user) begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else if (r_idx == LAST_IDX) begin
                            r_init_done <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= S_IDLE;
                        end else begin
                            r_idx        <= r_idx + 4'd1;
                            r_data_codec <= {SLAVE_ADDR, w_next_entry};
                            r_state      <= S_LOAD;
                        end
                    end else begin
                        r_gap <= r_gap + 8'd1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_usr_ack    = r_usr_ack;
    assign o_data_codec = r_data_codec;
    assign o_activate   = r_activate;
    assign o_busy       = r_busy;
    assign o_init_done  = r_init_done;
    assign o_err        = r_err;

endmodule
